// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg
//   Shared definitions for the MIPS pipeline register stages.
//   - NOP_INSTR_DEF : encoding of sll $0,$0,0, shown on decode when no entry is valid
//   - INSTR_W_DEF / ADDR_W_DEF : default instruction and PC field widths
//   - occ_e : occupancy of a 2-entry elastic stage (EMPTY, ONE, TWO)
package mips_pipe_pkg;

  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF  = 32;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage : mips_pipe_pkg

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf
//   Generic 2-entry elastic pipeline register with a registered upstream ready.
//   The main register always holds the oldest entry and drives the output; the
//   skid register absorbs the one extra word that can arrive while ready is
//   still high in the cycle the downstream side stalls.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   upstream word valid
//   in_ready_o   stage can accept (registered)
//   in_data_i    upstream word [W-1:0]
//   flush_i      synchronous squash of every held entry
//   out_valid_o  oldest entry valid
//   out_ready_i  downstream accepts this cycle
//   out_data_o   oldest entry [W-1:0] (raw register value, not masked)
//
// State table
//   EMPTY | no entry held, main/skid contents meaningless
//   ONE   | main holds the only entry
//   TWO   | main holds the oldest entry, skid the younger one; in_ready is low
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  input  logic         flush_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  occ_e         state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;

  logic in_fire;
  logic out_fire;

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign in_ready_o  = in_ready_q;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data_i;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          state_d = TWO;
          skid_d  = in_data_i;
        end
      end
      TWO: begin
        // in_ready is low here, so no input can fire
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Flush overrides everything: a same-cycle input is dropped and the
    // registers are cleared so no squashed word lingers in the datapath.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end

    // Registered ready: low exactly while the stage will be full.
    in_ready_d = (state_d != TWO);
  end

endmodule : pipe_skid_buf

// File: rtl/ifid_pipe_stage.sv
// ifid_pipe_stage
//   Elastic IF/ID pipeline register. Carries the fetched instruction and its
//   PC+4 to decode through a 2-entry skid buffer, supports squash on a taken
//   branch/jump, and shows a NOP with PC 0 whenever no entry is valid.
//
//   Optional build macro IFID_PERF_CNT_EN adds saturating stall and flush
//   counters as extra output ports.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   fetch presents an instruction
//   in_ready   stage can accept (registered)
//   in_instr   fetched instruction [INSTR_W-1:0]
//   in_pc      PC+4 of the fetched instruction [ADDR_W-1:0]
//   flush      squash every held entry
//   out_valid  decode-side entry valid
//   out_ready  decode accepts this cycle
//   out_instr  instruction to decode (NOP_INSTR when invalid)
//   out_pc     PC+4 to decode (0 when invalid)
//   stall_cnt  [IFID_PERF_CNT_EN] cycles with out_valid & !out_ready
//   flush_cnt  [IFID_PERF_CNT_EN] cycles with flush while not empty
module ifid_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int unsigned         INSTR_W   = INSTR_W_DEF,
  parameter int unsigned         ADDR_W    = ADDR_W_DEF,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  localparam int unsigned W = INSTR_W + ADDR_W;

  logic [W-1:0] buf_in_data;
  logic [W-1:0] buf_out_data;
  logic         buf_out_valid;

  assign buf_in_data = {in_pc, in_instr};

  pipe_skid_buf #(
    .W (W)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (buf_in_data),
    .flush_i     (flush),
    .out_valid_o (buf_out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (buf_out_data)
  );

  assign out_valid = buf_out_valid;

  // Mask so decode never sees stale register contents as a real instruction.
  assign out_instr = buf_out_valid ? buf_out_data[INSTR_W-1:0] : NOP_INSTR;
  assign out_pc    = buf_out_valid ? buf_out_data[W-1:INSTR_W] : '0;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // out_valid doubles as "not EMPTY", so a flush of an empty stage is not a squash.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (buf_out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (flush && buf_out_valid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule : ifid_pipe_stage

// File: tb/tb_ifid_pipe_stage.sv
module tb_ifid_pipe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  ifid_pipe_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // Reference model: the stage is a FIFO of at most two {pc,instr} words.
  logic [63:0] q[$];
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  int          m_consumed = 0;
  int          dut_consumed = 0;
  bit          last_fire = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_instr", 64'(out_instr), (q.size() > 0) ? 64'(q[0][31:0]) : 64'h0);
    chk("out_pc", 64'(out_pc), (q.size() > 0) ? 64'(q[0][63:32]) : 64'h0);
`ifdef IFID_PERF_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, then check.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    int  n;
    bit  inf, outf;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    if (out_valid && out_ready) dut_consumed++;
    n    = q.size();
    inf  = in_valid && (n < 2);
    outf = (n > 0) && out_ready;
    if (n > 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (flush && n > 0 && m_flush != 32'hFFFF_FFFF) m_flush++;
    if (outf) m_consumed++;
    if (flush) begin
      q.delete();
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back({in_pc, in_instr});
    end
    last_fire = inf;
    #1;
    check_all();
  endtask

  // Reset asserted between edges; outputs must react before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_stall = '0;
    m_flush = '0;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_out_instr", 64'(out_instr), 64'h0);
    chk("rst_out_pc", 64'(out_pc), 64'h0);
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_fire = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    bit          v, ordy, fl;
    logic [31:0] ins, pc;

    repeat (2) @(negedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // Stream a few, reset mid-stream, then the reference stream.
    step(1, 32'h1111_0000, 32'h100, 1, 0);
    step(1, 32'h1111_0001, 32'h104, 0, 0);
    async_reset();
    step(1, 32'h2008_0005, 32'h4, 1, 0);
    chk("first_instr", 64'(out_instr), 64'h2008_0005);
    chk("first_pc", 64'(out_pc), 64'h4);
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h2000_0000 + 32'(i), 32'h8 + 32'(4 * i), 1, 0);
      chk("stream_in_ready", 64'(in_ready), 64'h1);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Back-pressure into TWO, then drain in order.
    step(1, 32'h0000_0001, 32'h10, 0, 0);
    step(1, 32'h0000_0002, 32'h14, 0, 0);
    chk("bp_in_ready_low", 64'(in_ready), 64'h0);
    chk("bp_hold_A", 64'(out_instr), 64'h1);
    step(1, 32'h0000_0003, 32'h18, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("bp_then_B", 64'(out_instr), 64'h2);
    chk("bp_in_ready_back", 64'(in_ready), 64'h1);
    step(0, 0, 0, 1, 0);

    // Flush in TWO with a simultaneous input C that must be dropped.
    step(1, 32'h0000_000A, 32'h20, 0, 0);
    step(1, 32'h0000_000B, 32'h24, 0, 0);
    step(1, 32'h0000_0001, 32'h28, 1, 1);
    step(1, 32'h0000_000C, 32'h2C, 1, 1);
    chk("flush_empty", 64'(out_valid), 64'h0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Flush together with out_fire of A: A consumed exactly once.
    step(1, 32'h0000_00AA, 32'h30, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("flush_fire_in_ready", 64'(in_ready), 64'h1);
    step(0, 0, 0, 1, 0);
    chk("consumed_count", 64'(dut_consumed), 64'(m_consumed));

    // Async reset while TWO.
    step(1, 32'h0000_00D1, 32'h40, 0, 0);
    step(1, 32'h0000_00D2, 32'h44, 0, 0);
    async_reset();

`ifdef IFID_PERF_CNT_EN
    step(1, 32'h0000_00E1, 32'h50, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1);
    step(1, 32'h0000_00E2, 32'h54, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("perf_stall_5", 64'(stall_cnt), 64'd5);
    chk("perf_flush_2", 64'(flush_cnt), 64'd2);
`endif

    // Randomized traffic; producer holds its word until accepted.
    v = 0; ins = '0; pc = '0;
    for (int i = 0; i < 600; i++) begin
      if (!(v && !last_fire)) begin
        v   = ($urandom_range(0, 3) != 0);
        ins = $urandom;
        pc  = $urandom & 32'hFFFF_FFFC;
      end
      ordy = ($urandom_range(0, 4) > 1);
      fl   = ($urandom_range(0, 15) == 0);
      step(v, ins, pc, ordy, fl);
      if (fl) v = 0;
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("consumed_total", 64'(dut_consumed), 64'(m_consumed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifid_pipe_stage
